// File: rtl/timer_reg_pkg.sv
// Shared address map, reset values and helpers for the multi-channel timer register bank.
package timer_reg_pkg;

  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] THCSR_OFF = 12'h00C;
  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam logic [11:0] CH_STRIDE = 12'h010;

  localparam logic [3:0] TCMP0_OFF = 4'h0;
  localparam logic [3:0] TCMP1_OFF = 4'h4;
  localparam logic [3:0] TIER_OFF  = 4'h8;
  localparam logic [3:0] TISR_OFF  = 4'hC;

  localparam logic [63:0] CMP_RST         = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int unsigned DIV_VAL_RST     = 1;
  localparam int unsigned DIV_MAX_DEFAULT = 8;

  localparam logic [1:0] CNT_SEL_LO = 2'b01;
  localparam logic [1:0] CNT_SEL_HI = 2'b10;

  function automatic logic [31:0] strb_merge(input logic [31:0] cur, input logic [31:0] wdata,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_reg_chan.sv
// One compare/interrupt channel: TCMP0/TCMP1/TIER storage, TISR W1C pulse and local read data.
module timer_reg_chan
  import timer_reg_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sel,
  input  logic        wr,
  input  logic [3:0]  off,
  input  logic [31:0] wdata,
  input  logic [3:0]  strb,
  input  logic        int_status,
  output logic [63:0] compare_val,
  output logic        interrupt_en,
  output logic        interrupt_clear,
  output logic [31:0] rd_data
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      compare_val     <= CMP_RST;
      interrupt_en    <= 1'b0;
      interrupt_clear <= 1'b0;
    end else begin
      interrupt_clear <= wr & (off == TISR_OFF) & strb[0] & wdata[0];
      if (wr) begin
        case (off)
          TCMP0_OFF: compare_val[31:0]  <= strb_merge(compare_val[31:0], wdata, strb);
          TCMP1_OFF: compare_val[63:32] <= strb_merge(compare_val[63:32], wdata, strb);
          TIER_OFF:  if (strb[0]) interrupt_en <= wdata[0];
          default:   ;
        endcase
      end
    end
  end

  // Zero when not addressed so the top can OR all channels together.
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (off)
        TCMP0_OFF: rd_data = compare_val[31:0];
        TCMP1_OFF: rd_data = compare_val[63:32];
        TIER_OFF:  rd_data = {31'b0, interrupt_en};
        TISR_OFF:  rd_data = {31'b0, int_status};
        default:   rd_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/timer_reg_bank_mc.sv
// Timer register bank: decode, global control registers, atomic counter snapshot, read mux
// and error detection for NUM_CH compare/interrupt channels.
module timer_reg_bank_mc
  import timer_reg_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned DIV_MAX = DIV_MAX_DEFAULT
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [11:0]             tim_paddr,
  input  logic [31:0]             tim_pwdata,
  input  logic [3:0]              tim_pstrb,
  output logic [31:0]             tim_prdata,
  input  logic [CNT_W-1:0]        cnt_val,
  input  logic                    halt_ack_status,
  input  logic [NUM_CH-1:0]       interrupt_status,
  output logic                    timer_en,
  output logic                    div_en,
  output logic [DIV_W-1:0]        div_val,
  output logic                    halt_req,
  output logic [NUM_CH*CNT_W-1:0] compare_val,
  output logic [NUM_CH-1:0]       interrupt_en,
  output logic                    counter_clear,
  output logic [1:0]              counter_write_sel,
  output logic [31:0]             counter_write_data,
  output logic [NUM_CH-1:0]       interrupt_clear,
  output logic                    reg_error_flag
);

  localparam logic [DIV_W-1:0] DivMaxW = DIV_W'(DIV_MAX);

  logic                         is_tcr, is_tdr0, is_tdr1, is_thcsr, glob_hit, addr_ok;
  logic                         wr_act, rd_act, err_d;
  logic [NUM_CH-1:0]            ch_hit;
  logic [NUM_CH-1:0][31:0]      ch_rd;
  logic [31:0]                  tcr_cur, rd_data, snap_q;
  logic                         en_new, den_new, halt_new, div_reject;
  logic [DIV_W-1:0]             div_new;

  assign is_tcr   = tim_paddr == TCR_OFF;
  assign is_tdr0  = tim_paddr == TDR0_OFF;
  assign is_tdr1  = tim_paddr == TDR1_OFF;
  assign is_thcsr = tim_paddr == THCSR_OFF;
  assign glob_hit = is_tcr | is_tdr0 | is_tdr1 | is_thcsr;
  assign addr_ok  = glob_hit | (|ch_hit);

  // Zero-strobe writes are complete no-ops; a read colliding with a write is dropped.
  assign wr_act = wr_en & (|tim_pstrb) & addr_ok;
  assign rd_act = rd_en & ~wr_en;

  always_comb begin
    tcr_cur            = '0;
    tcr_cur[0]         = timer_en;
    tcr_cur[1]         = div_en;
    tcr_cur[8 +: DIV_W] = div_val;
  end

  assign en_new   = tim_pstrb[0] ? tim_pwdata[0] : timer_en;
  assign den_new  = tim_pstrb[0] ? tim_pwdata[1] : div_en;
  assign div_new  = tim_pstrb[1] ? tim_pwdata[8 +: DIV_W] : div_val;
  assign halt_new = tim_pstrb[0] ? tim_pwdata[0] : halt_req;

  // Divider fields are frozen while running and never accept an out-of-range divisor.
  assign div_reject = (div_new > DivMaxW) |
                      (timer_en & ((den_new != div_en) | (div_new != div_val)));

  assign err_d = (wr_en & rd_en) | (wr_en & (|tim_pstrb) & ~addr_ok) | (rd_act & ~addr_ok) |
                 (wr_act & is_tcr & div_reject);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    localparam logic [11:0] ChAddr = CH_BASE + 12'(n) * CH_STRIDE;

    assign ch_hit[n] = (tim_paddr[11:4] == ChAddr[11:4]) & (tim_paddr[1:0] == 2'b00);

    timer_reg_chan u_chan (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .sel             (ch_hit[n]),
      .wr              (wr_act & ch_hit[n]),
      .off             (tim_paddr[3:0]),
      .wdata           (tim_pwdata),
      .strb            (tim_pstrb),
      .int_status      (interrupt_status[n]),
      .compare_val     (compare_val[n*CNT_W +: 64]),
      .interrupt_en    (interrupt_en[n]),
      .interrupt_clear (interrupt_clear[n]),
      .rd_data         (ch_rd[n])
    );
  end

  always_comb begin
    rd_data = '0;
    if (is_tcr)        rd_data = tcr_cur;
    else if (is_tdr0)  rd_data = cnt_val[31:0];
    else if (is_tdr1)  rd_data = snap_q;
    else if (is_thcsr) rd_data = {30'b0, halt_ack_status, halt_req};
    for (int n = 0; n < NUM_CH; n++) rd_data = rd_data | ch_rd[n];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_en           <= 1'b0;
      div_en             <= 1'b0;
      div_val            <= DIV_W'(DIV_VAL_RST);
      halt_req           <= 1'b0;
      counter_clear      <= 1'b0;
      counter_write_sel  <= '0;
      counter_write_data <= '0;
      reg_error_flag     <= 1'b0;
      tim_prdata         <= '0;
      snap_q             <= '0;
    end else begin
      counter_clear     <= 1'b0;
      counter_write_sel <= '0;
      reg_error_flag    <= err_d;
      if (wr_act && is_tcr) begin
        timer_en      <= en_new;
        counter_clear <= timer_en & ~en_new;
        if (!div_reject) begin
          div_en  <= den_new;
          div_val <= div_new;
        end
      end
      if (wr_act && is_thcsr) halt_req <= halt_new;
      if (wr_act && is_tdr0) begin
        counter_write_sel  <= CNT_SEL_LO;
        counter_write_data <= strb_merge(cnt_val[31:0], tim_pwdata, tim_pstrb);
      end
      if (wr_act && is_tdr1) begin
        counter_write_sel  <= CNT_SEL_HI;
        counter_write_data <= strb_merge(cnt_val[63:32], tim_pwdata, tim_pstrb);
      end
      if (rd_act) begin
        tim_prdata <= rd_data;
        // Upper word is frozen here so a following TDR1 read is coherent with this TDR0 read.
        if (is_tdr0) snap_q <= cnt_val[63:32];
      end
    end
  end

endmodule

// File: tb/tb_timer_reg_bank_mc.sv
// Scoreboard bench for timer_reg_bank_mc: a register-level model pushes the expected state
// for every cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_timer_reg_bank_mc;
  localparam int NCH = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              wr_en = 1'b0, rd_en = 1'b0;
  logic [11:0]       tim_paddr = '0;
  logic [31:0]       tim_pwdata = '0;
  logic [3:0]        tim_pstrb = '0;
  logic [31:0]       tim_prdata;
  logic [63:0]       cnt_val = '0;
  logic              halt_ack_status = 1'b0;
  logic [NCH-1:0]    interrupt_status = '0;
  logic              timer_en, div_en, halt_req, counter_clear, reg_error_flag;
  logic [3:0]        div_val;
  logic [NCH*64-1:0] compare_val;
  logic [NCH-1:0]    interrupt_en, interrupt_clear;
  logic [1:0]        counter_write_sel;
  logic [31:0]       counter_write_data;

  always #5 sys_clk = ~sys_clk;

  timer_reg_bank_mc #(.NUM_CH(NCH)) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .wr_en              (wr_en),
    .rd_en              (rd_en),
    .tim_paddr          (tim_paddr),
    .tim_pwdata         (tim_pwdata),
    .tim_pstrb          (tim_pstrb),
    .tim_prdata         (tim_prdata),
    .cnt_val            (cnt_val),
    .halt_ack_status    (halt_ack_status),
    .interrupt_status   (interrupt_status),
    .timer_en           (timer_en),
    .div_en             (div_en),
    .div_val            (div_val),
    .halt_req           (halt_req),
    .compare_val        (compare_val),
    .interrupt_en       (interrupt_en),
    .counter_clear      (counter_clear),
    .counter_write_sel  (counter_write_sel),
    .counter_write_data (counter_write_data),
    .interrupt_clear    (interrupt_clear),
    .reg_error_flag     (reg_error_flag)
  );

  typedef struct packed {
    logic [31:0]  prdata;
    logic         ten;
    logic         den;
    logic [3:0]   dval;
    logic         halt;
    logic [255:0] cmp;
    logic [3:0]   ier;
    logic         clr;
    logic [1:0]   sel;
    logic [31:0]  cwd;
    logic [3:0]   iclr;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Register-level model state
  logic        m_ten, m_den, m_halt;
  logic [3:0]  m_dval, m_ier;
  logic [63:0] m_cmp [NCH];
  logic [31:0] m_snap, m_prd, m_cwd;

  logic [11:0] bad_addr [8] = '{12'h010, 12'h0FC, 12'h140, 12'h14C, 12'h102, 12'h001,
                                12'h200, 12'hFFC};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ten = 0; m_den = 0; m_halt = 0; m_dval = 4'd1; m_ier = '0;
    m_snap = '0; m_prd = '0; m_cwd = '0;
    for (int c = 0; c < NCH; c++) m_cmp[c] = '1;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] s, input logic [63:0] cnt,
                            input logic [3:0] ists, input logic hack);
    exp_t        e;
    logic [31:0] t;
    bit          legal;
    int          ai, ch, off;
    ai    = int'(a);
    legal = (ai % 4 == 0) && (ai < 16 || (ai >= 256 && ai < 256 + 16 * NCH));
    ch    = (ai - 256) / 16;
    off   = ai % 16;
    e     = '0;
    if (w && r) e.err = 1'b1;
    if (w && s != 4'b0) begin
      if (!legal) e.err = 1'b1;
      else if (ai == 0) begin
        t = merge({20'b0, m_dval, 6'b0, m_den, m_ten}, d, s);
        if (t[11:8] > 4'd8 || (m_ten && (t[1] != m_den || t[11:8] != m_dval))) e.err = 1'b1;
        else begin
          m_den  = t[1];
          m_dval = t[11:8];
        end
        e.clr = m_ten && !t[0];
        m_ten = t[0];
      end else if (ai == 4) begin
        e.sel = 2'b01; m_cwd = merge(cnt[31:0], d, s);
      end else if (ai == 8) begin
        e.sel = 2'b10; m_cwd = merge(cnt[63:32], d, s);
      end else if (ai == 12) begin
        t = merge({31'b0, m_halt}, d, s); m_halt = t[0];
      end else if (off == 0) begin
        t = merge(m_cmp[ch][31:0], d, s); m_cmp[ch][31:0] = t;
      end else if (off == 4) begin
        t = merge(m_cmp[ch][63:32], d, s); m_cmp[ch][63:32] = t;
      end else if (off == 8) begin
        t = merge({31'b0, m_ier[ch]}, d, s); m_ier[ch] = t[0];
      end else e.iclr[ch] = s[0] && d[0];
    end
    if (r && !w) begin
      if (!legal) begin
        e.err = 1'b1; m_prd = '0;
      end else if (ai == 0) m_prd = {20'b0, m_dval, 6'b0, m_den, m_ten};
      else if (ai == 4) begin
        m_prd = cnt[31:0]; m_snap = cnt[63:32];
      end else if (ai == 8)  m_prd = m_snap;
      else if (ai == 12)     m_prd = {30'b0, hack, m_halt};
      else if (off == 0)     m_prd = m_cmp[ch][31:0];
      else if (off == 4)     m_prd = m_cmp[ch][63:32];
      else if (off == 8)     m_prd = {31'b0, m_ier[ch]};
      else                   m_prd = {31'b0, ists[ch]};
    end
    e.prdata = m_prd; e.ten = m_ten; e.den = m_den; e.dval = m_dval; e.halt = m_halt;
    e.ier = m_ier; e.cwd = m_cwd;
    for (int c = 0; c < NCH; c++) e.cmp[c*64 +: 64] = m_cmp[c];
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [63:0] cnt, input logic [3:0] ists,
                       input logic hack);
    @(negedge sys_clk);
    #1;
    wr_en = w; rd_en = r; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
    cnt_val = cnt; interrupt_status = ists; halt_ack_status = hack;
    model_step(w, r, a, d, s, cnt, ists, hack);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, cnt_val, interrupt_status, halt_ack_status);
  endtask

  // Monitor: every cycle's outputs are compared against the oldest pending expectation.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("prdata",    256'(tim_prdata),         256'(e.prdata));
      chk("timer_en",  256'(timer_en),           256'(e.ten));
      chk("div_en",    256'(div_en),             256'(e.den));
      chk("div_val",   256'(div_val),            256'(e.dval));
      chk("halt_req",  256'(halt_req),           256'(e.halt));
      chk("cmp_val",   256'(compare_val),        e.cmp);
      chk("int_en",    256'(interrupt_en),       256'(e.ier));
      chk("cnt_clr",   256'(counter_clear),      256'(e.clr));
      chk("cnt_sel",   256'(counter_write_sel),  256'(e.sel));
      chk("cnt_wdata", 256'(counter_write_data), 256'(e.cwd));
      chk("int_clr",   256'(interrupt_clear),    256'(e.iclr));
      chk("reg_err",   256'(reg_error_flag),     256'(e.err));
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge sys_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_prdata"},  256'(tim_prdata),         256'(0));
    chk({tag, "_ten"},     256'(timer_en),           256'(0));
    chk({tag, "_den"},     256'(div_en),             256'(0));
    chk({tag, "_dval"},    256'(div_val),            256'(1));
    chk({tag, "_halt"},    256'(halt_req),           256'(0));
    chk({tag, "_cmp"},     256'(compare_val),        {256{1'b1}});
    chk({tag, "_ier"},     256'(interrupt_en),       256'(0));
    chk({tag, "_clr"},     256'(counter_clear),      256'(0));
    chk({tag, "_sel"},     256'(counter_write_sel),  256'(0));
    chk({tag, "_cwd"},     256'(counter_write_data), 256'(0));
    chk({tag, "_iclr"},    256'(interrupt_clear),    256'(0));
    chk({tag, "_err"},     256'(reg_error_flag),     256'(0));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_reset_state("rst");
    #1 sys_rst_n = 1'b1;

    // Reset reads: TCR, ch2 TCMP0, out-of-range channel 4
    drive(1'b0, 1'b1, 12'h000, 32'h0, 4'h0, 64'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 12'h120, 32'h0, 4'h0, 64'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 12'h140, 32'h0, 4'h0, 64'h0, 4'h0, 1'b0);
    idle();
    // TCR enable with divider, then a rejected divider change while running
    drive(1'b1, 1'b0, 12'h000, 32'h0000_0503, 4'hF, 64'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 32'h0000_0603, 4'hF, 64'h0, 4'h0, 1'b0);
    idle();
    // Partial-strobe compare write on channel 1
    drive(1'b1, 1'b0, 12'h110, 32'h1234_5678, 4'b0011, 64'h0, 4'h0, 1'b0);
    // Atomic 64-bit counter read
    drive(1'b0, 1'b1, 12'h004, 32'h0, 4'h0, 64'hAAAA_BBBB_C0C0_DADA, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 12'h008, 32'h0, 4'h0, 64'h1111_2222_3333_4444, 4'h0, 1'b0);
    // W1C on channel 3, then a write that misses byte 0
    drive(1'b1, 1'b0, 12'h13C, 32'h1, 4'h1, 64'h0, 4'h8, 1'b0);
    idle();
    drive(1'b1, 1'b0, 12'h13C, 32'h1, 4'h2, 64'h0, 4'h8, 1'b0);
    idle();
    // timer_en 1 -> 0 produces a single counter_clear pulse
    drive(1'b1, 1'b0, 12'h000, 32'h0000_0501, 4'hF, 64'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 32'h0000_0500, 4'hF, 64'h0, 4'h0, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      int          op, k;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = bad_addr[$urandom_range(0, 7)];
      else begin
        k = $urandom_range(0, 19);
        a = (k < 4) ? 12'(k * 4) : 12'(256 + (k - 4) * 4);
      end
      d = $urandom;
      if (a == 12'h000 && $urandom_range(0, 1) == 1)
        d = {20'b0, 4'($urandom_range(0, 10)), 6'b0, 2'($urandom_range(0, 3))};
      s = 4'($urandom);
      if (s == 4'h0 && $urandom_range(0, 3) != 0) s = 4'hF;
      drive(op == 1 || (op >= 2 && op <= 5), op == 1 || op >= 6, a, d, s,
            {$urandom, $urandom}, 4'($urandom), 1'($urandom));
    end
    idle();
    drain();

    // Make state non-trivial, then reset in the middle of a write access
    drive(1'b1, 1'b0, 12'h00C, 32'h1, 4'h1, 64'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 12'h104, 32'h0, 4'hF, 64'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 32'h1, 4'h1, 64'h0, 4'h0, 1'b0);
    idle();
    drain();
    @(negedge sys_clk);
    #1;
    wr_en = 1'b1; tim_paddr = 12'h000; tim_pwdata = 32'h0; tim_pstrb = 4'hF;
    #2 sys_rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    #5 check_reset_state("held_rst");
    wr_en = 1'b0;
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_reg_bank_mc.md
Name: timer_reg_bank_mc

Overview:
Multi-channel register bank for the timer. It is the parametrised successor of the single-channel `register` block and serves NUM_CH independent compare/interrupt channels from one shared counter. It decodes APB-qualified wr_en/rd_en accesses, holds control and compare state, generates one-cycle command pulses, and returns registered read data with an atomic 64-bit counter snapshot. It sits between the APB slave front-end and the counter, prescaler and interrupt logic.

Parameters:
NUM_CH, 4, number of compare/interrupt channels (1..8)
CNT_W, 64, counter width; must be 64 (read as two 32-bit words)
DIV_W, 4, divider-value field width
DIV_MAX, 8, largest legal div_val

Ports:
sys_clk  in  1  single clock, rising edge
sys_rst_n  in  1  asynchronous reset, active low
wr_en  in  1  write strobe (APB access phase), one cycle per access
rd_en  in  1  read strobe (APB access phase), one cycle per access
tim_paddr  in  12  byte address, word aligned
tim_pwdata  in  32  write data
tim_pstrb  in  4  byte strobes
tim_prdata  out  32  registered read data
cnt_val  in  CNT_W  live counter value
halt_ack_status  in  1  halt acknowledge from counter
interrupt_status  in  NUM_CH  per-channel pending flag from interrupt logic
timer_en  out  1  TCR[0]
div_en  out  1  TCR[1]
div_val  out  DIV_W  TCR[11:8]
halt_req  out  1  THCSR[0]
compare_val  out  NUM_CH*CNT_W  packed compare values, channel 0 in the LSBs
interrupt_en  out  NUM_CH  per-channel TIER[0]
counter_clear  out  1  one-cycle pulse
counter_write_sel  out  2  one-cycle pulse: 01 = low word, 10 = high word
counter_write_data  out  32  strobe-merged data for a counter write
interrupt_clear  out  NUM_CH  one-cycle W1C pulses
reg_error_flag  out  1  one-cycle pulse on an illegal access

Behaviour:
- Address map:
  - 0x000 TCR
  - 0x004 TDR0
  - 0x008 TDR1
  - 0x00C THCSR
  - Per channel n at 0x100 + n*0x10: +0x0 TCMP0, +0x4 TCMP1, +0x8 TIER, +0xC TISR.
- Reset values:
  - All outputs are 0, except compare_val, which resets to all ones for every channel.
  - div_val resets to 1.
  - tim_prdata resets to 0. Snapshot register resets to 0.
- Writes:
  - Take effect at the rising edge where wr_en=1.
  - Only bytes with tim_pstrb set are updated. Writes with tim_pstrb=0 have no effect and raise no error.
- TCR write, rejected case:
  - If timer_en is 1 and the write would change div_en or div_val, those fields keep their old value and reg_error_flag pulses.
  - timer_en in the same write still updates.
- TCR write, illegal divider:
  - A new div_val greater than DIV_MAX is rejected and reg_error_flag pulses.
- TCR timer_en transition:
  - A 1→0 transition of timer_en pulses counter_clear on the following cycle.
- TDR0/TDR1 writes:
  - Pulse counter_write_sel (01 for TDR0, 10 for TDR1) for exactly one cycle after the write edge.
  - counter_write_data = tim_pwdata merged per byte with the current cnt_val word.
- TISR write:
  - Writing with tim_pstrb[0]=1 and pwdata[0]=1 pulses interrupt_clear[n] for one cycle.
  - Read value = {31'b0, interrupt_status[n]}.
- THCSR:
  - Bit 0 is halt_req (R/W).
  - Bit 1 is halt_ack_status (read-only).
- Reads:
  - Latency 1. tim_prdata is loaded at the edge where rd_en=1 and holds its value until the next read.
- Atomic counter read:
  - Reading TDR0 returns cnt_val[31:0] and captures cnt_val[63:32] into the snapshot in the same edge.
  - Reading TDR1 returns the snapshot, not the live value.
  - A TDR1 read with no prior TDR0 read returns the last snapshot (0 after reset).
- Unmapped or out-of-range accesses:
  - Includes channel index ≥ NUM_CH and misaligned addresses.
  - Reads return 0. Writes are ignored. Both pulse reg_error_flag.
- wr_en and rd_en both high:
  - The write is performed, the read is ignored, and reg_error_flag pulses.
- Reset asserted mid-access:
  - All state returns to reset values immediately.
  - Pending pulses are dropped.

Decomposition:
- Package timer_reg_pkg holds:
  - Address offset constants (TCR, TDR0, TDR1, THCSR, CH_BASE, CH_STRIDE, TCMP0, TCMP1, TIER, TISR).
  - Reset constants (compare reset value, div_val reset value).
  - DIV_MAX and the counter_write_sel encodings.
- Sub-module timer_reg_chan, instanced NUM_CH times, holds one channel's TCMP0/TCMP1/TIER storage, strobe merge and W1C pulse.
- The top level does decode, global registers, snapshot, read mux and error detection.

Test Plan:
- Reset, then read TCR, TCMP0 of channel 2 and 0x100 + 4*0x10 -> 0x00000100, 0xFFFFFFFF, 0 with reg_error_flag=1 for one cycle (NUM_CH=4).
- Write 0x00000503 with tim_pstrb=4'hF to TCR, then write 0x00000603 -> timer_en=1, div_en=1, div_val=5 after the first write; div_val stays 5 and reg_error_flag pulses on the second.
- Write 0x12345678 with tim_pstrb=4'b0011 to channel 1 TCMP0 -> compare_val[95:64] = 0xFFFF5678; other channels unchanged.
- Set cnt_val=0xAAAABBBB_C0C0DADA, read TDR0, change cnt_val to 0x11112222_33334444, read TDR1 -> 0xC0C0DADA then 0xAAAABBBB.
- Write 1 to channel 3 TISR with tim_pstrb=4'h1 -> interrupt_clear=4'b1000 for exactly one cycle; a write with tim_pstrb=4'h2 produces no pulse.
- Write TCR=1, then TCR=0, then assert sys_rst_n=0 mid-write -> counter_clear pulses once after the 1→0 write; all outputs return to reset values asynchronously.
